mul_sequencer: RTL and testbench
================================

# mul_sequencer

Sequencing controller for the multiply path of the single-cycle core. It accepts a decoded MUL instruction and runs a 32-iteration shift-add multiply. While the multiply is in progress it stalls the PC. When the result is ready it presents it to the register write-back mux for exactly one cycle, using the `mul_ready`/`mul_out` pair, together with the destination register index.

## Interface
- `XLEN`, default 32: operand and result width.
- `RD_W`, default 5: destination register index width.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `mul_valid` input 1: current instruction is MUL. Held high by the core for as long as that instruction is stalled.
- `in_a` input XLEN: rs1 value.
- `in_b` input XLEN: rs2 value.
- `rd_in` input RD_W: destination register index.
- `stall` output 1: freeze PC and register write of the current instruction.
- `busy` output 1: multiply iterating (state BUSY).
- `mul_ready` output 1: one-cycle result-valid strobe to the write-back mux.
- `mul_out` output XLEN: product, low XLEN bits.
- `mul_rd` output RD_W: destination index for `mul_out`.

## Operation
The controller has three states: IDLE, BUSY and DONE.

- **IDLE**
  - If `mul_valid`=1: capture `in_a` into the multiplicand register, `in_b` into the multiplier register and `rd_in` into `mul_rd`. Clear the accumulator and set the iteration counter to 0. Go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**, per cycle:
  - If multiplier[0]=1, accumulator += multiplicand (modulo 2^XLEN).
  - Shift the multiplicand left 1 and the multiplier right 1 (logical).
  - Increment the counter.
  - After the iteration with counter == XLEN-1, go to DONE.
  - The iteration count is fixed; there is no early exit on a zero multiplier.
- **DONE**
  - `mul_ready`=1. `mul_out` = accumulator (a registered value).
  - Go to IDLE unconditionally. `mul_valid` is ignored in this state; it is still high for the retiring instruction and must not retrigger a multiply.

Arithmetic rules:
- The result is the low XLEN bits of `in_a`*`in_b`. It is identical for signed and unsigned operands, so there is no sign handling.
- The accumulator is XLEN bits; carries beyond XLEN are dropped.

Output decoding:
- `stall` = rst_n & ((IDLE & `mul_valid`) | BUSY). The IDLE term is combinational so the MUL instruction never retires in its first cycle.
- `busy` = rst_n & BUSY.
- `mul_ready` = rst_n & DONE.
- `mul_out` and `mul_rd` hold their last values outside DONE. The write-back mux qualifies them with `mul_ready`.

## Timing
- Cycle 0 is the first cycle in which `mul_valid`=1 while in IDLE.
  - `stall`=1 in cycles 0..32.
  - BUSY occupies cycles 1..32.
  - DONE is cycle 33: `mul_ready`=1, `stall`=0, and the PC advances at the end of cycle 33.
- Latency is 33 cycles from acceptance to the `mul_ready` strobe. The `mul_ready` pulse width is exactly 1 cycle.
- Back-to-back MULs: a MUL arriving in cycle 34 (IDLE) is accepted immediately. There are no extra bubbles.
- Reset (`rst_n`=0 sampled at a rising edge):
  - State goes to IDLE. Counter, accumulator, multiplicand, multiplier, `mul_out` and `mul_rd` are cleared to 0.
  - While `rst_n`=0, `stall`, `busy` and `mul_ready` are forced to 0 combinationally.
  - Reset mid-BUSY or in DONE aborts the operation with no `mul_ready` pulse.
- After `rst_n` returns to 1, a held `mul_valid` starts a fresh operation from cycle 0.
- Operand changes on `in_a`/`in_b`/`rd_in` after cycle 0 have no effect on the result.

## Test plan
- `in_a`=3, `in_b`=5, `rd_in`=7, `mul_valid` held until `stall` drops -> `stall` high 33 cycles; `mul_ready` pulses once in cycle 33 with `mul_out`=15 and `mul_rd`=7.
- `in_a`=0xFFFFFFFF, `in_b`=0xFFFFFFFF -> `mul_out`=0x00000001. `in_a`=0x80000000, `in_b`=2 -> `mul_out`=0.
- `in_a`=0x12345678, `in_b`=0 -> after a full 33-cycle latency, `mul_out`=0 (no early exit).
- Two MULs back-to-back (6*7 to rd 1, then 9*9 to rd 2) -> `mul_ready` in cycles 33 and 67 with 42/rd1 and 81/rd2; `stall` low only in cycles 33 and 67.
- `mul_valid` kept high through DONE -> exactly one `mul_ready` pulse, and the state returns to IDLE, not BUSY.
- `rst_n`=0 during cycle 10 of a 100*100 operation -> next cycle IDLE with all registers 0 and no `mul_ready`. After release with `mul_valid` high, `mul_out`=10000 arrives 33 cycles later.

Source files
------------

// File: rtl/mul_sequencer.sv
// Sequencing controller for the multiply path: a fixed 32-iteration shift-add
// multiply that stalls the PC and strobes the product to write-back for one cycle.
`timescale 1ns/1ps
module mul_sequencer #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_valid,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] rd_in,
  output logic            stall,
  output logic            busy,
  output logic            mul_ready,
  output logic [XLEN-1:0] mul_out,
  output logic [RD_W-1:0] mul_rd
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [XLEN-1:0]   mcand_q,  mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [XLEN-1:0]   out_q,    out_d;
  logic [RD_W-1:0]   rd_q,     rd_d;

  // Next-state and datapath update for one shift-add iteration per BUSY cycle.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    rd_d     = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_valid) begin
          mcand_d  = in_a;
          mplier_d = in_b;
          rd_d     = rd_in;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The product register is loaded with the final sum so DONE presents a flop.
        if (cnt_q == LAST_ITER) begin
          out_d   = acc_d;
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        // mul_valid is still high for the retiring instruction; never re-accept here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rd_q     <= rd_d;
    end
  end

  // The IDLE stall term is combinational so a MUL never retires in its first cycle.
  assign stall     = rst_n & (((state_q == ST_IDLE) & mul_valid) | (state_q == ST_BUSY));
  assign busy      = rst_n & (state_q == ST_BUSY);
  assign mul_ready = rst_n & (state_q == ST_DONE);
  assign mul_out   = out_q;
  assign mul_rd    = rd_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: latency, strobe width, arithmetic corners,
// back-to-back issue and mid-operation reset, all against hand-computed values.
`timescale 1ns/1ps
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  rd_in;
  logic        stall;
  logic        busy;
  logic        mul_ready;
  logic [31:0] mul_out;
  logic [4:0]  mul_rd;

  int checks = 0;
  int errors = 0;

  mul_sequencer #(.XLEN(32), .RD_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mul_valid (mul_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .rd_in     (rd_in),
    .stall     (stall),
    .busy      (busy),
    .mul_ready (mul_ready),
    .mul_out   (mul_out),
    .mul_rd    (mul_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one MUL starting in the next cycle and checks cycles 0..33; returns in cycle 33.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
    for (int c = 0; c <= 33; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        rst_n     = 1'b1;
        mul_valid = 1'b1;
        in_a      = a;
        in_b      = b;
        rd_in     = rd;
      end else if (c == 1) begin
        in_a  = ~a;
        in_b  = a ^ b ^ 32'h0000_0001;
        rd_in = ~rd;
      end
      @(negedge clk);
      chk($sformatf("stall c%0d", c), 64'(stall), 64'(c <= 32));
      chk($sformatf("busy c%0d", c), 64'(busy), 64'((c >= 1) && (c <= 32)));
      chk($sformatf("ready c%0d", c), 64'(mul_ready), 64'(c == 33));
      if (c == 33) begin
        chk($sformatf("mul_out %0h*%0h", a, b), 64'(mul_out), 64'(exp));
        chk($sformatf("mul_rd %0h*%0h", a, b), 64'(mul_rd), 64'(rd));
      end
    end
  endtask

  // Drops mul_valid in the cycle after DONE and checks nothing restarted.
  task automatic idle_step(input logic [31:0] exp_out, input logic [4:0] exp_rd);
    @(posedge clk); #1;
    mul_valid = 1'b0;
    @(negedge clk);
    chk("idle stall", 64'(stall), 64'd0);
    chk("idle busy", 64'(busy), 64'd0);
    chk("idle ready", 64'(mul_ready), 64'd0);
    chk("hold mul_out", 64'(mul_out), 64'(exp_out));
    chk("hold mul_rd", 64'(mul_rd), 64'(exp_rd));
  endtask

  initial begin
    rst_n     = 1'b0;
    mul_valid = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    rd_in     = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst ready", 64'(mul_ready), 64'd0);
    chk("rst mul_out", 64'(mul_out), 64'd0);
    chk("rst mul_rd", 64'(mul_rd), 64'd0);
    mul_valid = 1'b1;
    #1;
    chk("rst stall forced", 64'(stall), 64'd0);

    run_mul(32'd3, 32'd5, 5'd7, 32'd15);
    idle_step(32'd15, 5'd7);

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);
    idle_step(32'h0000_0001, 5'd4);

    run_mul(32'h8000_0000, 32'd2, 5'd5, 32'd0);
    idle_step(32'd0, 5'd5);

    run_mul(32'h1234_5678, 32'd0, 5'd6, 32'd0);
    idle_step(32'd0, 5'd6);

    // Back-to-back: second MUL is accepted in cycle 34, ready in cycle 67.
    run_mul(32'd6, 32'd7, 5'd1, 32'd42);
    run_mul(32'd9, 32'd9, 5'd2, 32'd81);
    idle_step(32'd81, 5'd2);

    // Reset in cycle 10 of 100*100 aborts without a strobe.
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        mul_valid = 1'b1;
        in_a      = 32'd100;
        in_b      = 32'd100;
        rd_in     = 5'd3;
      end else if (c == 10) begin
        rst_n = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("abort stall c%0d", c), 64'(stall), 64'(c < 10));
      chk($sformatf("abort ready c%0d", c), 64'(mul_ready), 64'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-rst busy", 64'(busy), 64'd0);
    chk("post-rst ready", 64'(mul_ready), 64'd0);
    chk("post-rst mul_out", 64'(mul_out), 64'd0);
    chk("post-rst mul_rd", 64'(mul_rd), 64'd0);

    run_mul(32'd100, 32'd100, 5'd3, 32'd10000);
    idle_step(32'd10000, 5'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
